lut_mux_pipe: RTL and testbench

- Parametrised, programmable successor to the fixed 4-to-1 truth-table mux.
- Stores a 2^SEL_W-entry table of DATA_W-bit words. At reset the table loads from INIT; software can rewrite it at run time through a write port.
- Lookups pass through one registered stage with a valid/ready handshake, so the block drops into streaming datapaths as a programmable combinational-function generator.

---
 rtl/lut_mux_pipe.sv | 64 ++++++
 tb/tb_lut_mux_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lut_mux_pipe.sv
// Programmable lookup table (2^SEL_W entries of DATA_W bits) with one registered
// output stage behind a valid/ready handshake; the table is rewritable at run time.
module lut_mux_pipe #(
    parameter int SEL_W = 2,
    parameter int DATA_W = 1,
    parameter logic [DATA_W*(2**SEL_W)-1:0] INIT = 4'b0110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              in_valid,
    input  logic [SEL_W-1:0]  in_sel,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);
    localparam int DEPTH = 2 ** SEL_W;

    logic [DATA_W-1:0] lut_q [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              accept;

    // Handshake: a transfer happens on any rising edge where valid && ready are both
    // high; valid never drops and data never changes while waiting for ready.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Explicit read mux over the register array keeps this a plain flop table.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                rd_data = lut_q[k];
            end
        end
    end

    // The lookup above reads lut_q before this edge's write lands (read-before-write).
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rst) begin
                lut_q[k] <= INIT[k*DATA_W +: DATA_W];
            end else if (cfg_we && (cfg_addr == SEL_W'(k))) begin
                lut_q[k] <= cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_mux_pipe.sv
// Bench for lut_mux_pipe: two configurations (default 4x1 XOR table and an 8x8 table)
// share one stimulus stream; a queue-based scoreboard checks the joined outputs.
module tb_lut_mux_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       in_valid;
    logic [2:0] in_sel;
    logic       out_ready;

    logic       in_ready0, out_valid0;
    logic [0:0] out_data0;
    logic       in_ready1, out_valid1;
    logic [7:0] out_data1;

    localparam logic [63:0] INIT8 = {8'd21, 8'd18, 8'd15, 8'd12, 8'd9, 8'd6, 8'd3, 8'd0};

    always #5 clk = ~clk;

    lut_mux_pipe u_dut0 (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr[1:0]), .cfg_data(cfg_data[0:0]),
        .in_valid(in_valid), .in_sel(in_sel[1:0]), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready)
    );

    lut_mux_pipe #(.SEL_W(3), .DATA_W(8), .INIT(INIT8)) u_dut1 (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready)
    );

    // Reference model: tables, pending-result flag, last emitted word, expected queue.
    logic       tbl0 [4];
    logic [7:0] tbl1 [8];
    logic [8:0] exp_q[$];
    logic [8:0] last_out;
    int         pending;
    int         checks = 0;
    int         errors = 0;
    bit         started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) tbl0[k] = k[0] ^ k[1];
        for (int k = 0; k < 8; k++) tbl1[k] = 8'(k * 3);
    endtask

    // One clock of stimulus plus the model's view of that edge.
    task automatic cycle(input logic r, input logic we, input logic [2:0] a,
                         input logic [7:0] d, input logic v, input logic [2:0] s,
                         input logic o);
        logic rdy;
        rst = r; cfg_we = we; cfg_addr = a; cfg_data = d;
        in_valid = v; in_sel = s; out_ready = o;
        @(negedge clk);
        rdy = (pending == 0) || o;
        chk("in_ready0", 32'(in_ready0), 32'(rdy));
        chk("in_ready1", 32'(in_ready1), 32'(rdy));
        chk("out_valid", 32'({out_valid1, out_valid0}), (pending != 0) ? 32'd3 : 32'd0);
        if (pending == 0) chk("held_data", 32'({out_data1, out_data0}), 32'(last_out));
        @(posedge clk);
        if (r) begin
            pending = 0;
            exp_q.delete();
            last_out = '0;
            model_reset();
        end else begin
            if (v && rdy) begin
                last_out = {tbl1[s], tbl0[s[1:0]]};
                exp_q.push_back(last_out);
                pending = 1;
            end else if (o) begin
                pending = 0;
            end
            if (we) begin
                tbl0[a[1:0]] = d[0];
                tbl1[a] = d;
            end
        end
        #1;
    endtask

    task automatic lookup(input logic [2:0] s);
        cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, s, 1'b1);
    endtask

    task automatic idle(input logic o);
        cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, o);
    endtask

    // Monitor: whenever a result is presented it must match the queue head;
    // a completed handshake retires it.
    always @(negedge clk) begin
        if (started && (out_valid0 || out_valid1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_data: got %0h expected no result", {out_data1, out_data0});
            end else begin
                chk("out_data", 32'({out_data1, out_data0}), 32'(exp_q[0]));
                if (out_ready && !rst) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_sel = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        pending = 0;
        last_out = '0;
        started = 1'b1;

        // Default XOR table, full-throughput lookups.
        for (int s = 0; s < 4; s++) lookup(3'(s));
        idle(1'b1);

        // Reprogram as AND, read back, then reset restores INIT.
        for (int a = 0; a < 4; a++) cycle(1'b0, 1'b1, 3'(a), (a == 3) ? 8'd1 : 8'd0, 1'b0, 3'd0, 1'b1);
        for (int s = 0; s < 4; s++) lookup(3'(s));
        idle(1'b1);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1);
        idle(1'b1);
        for (int s = 0; s < 4; s++) lookup(3'(s));
        idle(1'b1);

        // Stall with a request waiting, then release.
        lookup(3'd1);
        repeat (3) cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd0, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd0, 1'b1);
        idle(1'b1);

        // Write and lookup of the same entry on one edge: old value first.
        cycle(1'b0, 1'b1, 3'd2, 8'd0, 1'b1, 3'd2, 1'b1);
        lookup(3'd2);
        idle(1'b1);

        // Full 8-entry sweep, then overwrite the last entry.
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1);
        for (int s = 0; s < 8; s++) lookup(3'(s));
        cycle(1'b0, 1'b1, 3'd7, 8'hFF, 1'b0, 3'd0, 1'b1);
        lookup(3'd7);
        idle(1'b1);

        // Reset while a result is stalled: it is discarded.
        lookup(3'd1);
        idle(1'b0);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 3'd3, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0));
        end
        repeat (3) idle(1'b1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
